// File: rtl/bus_pkg.sv
// bus_pkg: shared types and defaults for the 68000 bus-cycle responder.
//   target_e       latched target code reported on Target
//   state_e        responder FSM states
//   DEF_*          default wait-state counts, timeout and counter width
//   decode_target  priority decode of the decoder select lines
//   multi_select   true when two or more selects are high
package bus_pkg;

  typedef enum logic [2:0] {
    TGT_NONE     = 3'd0,
    TGT_ROM      = 3'd1,
    TGT_RAM      = 3'd2,
    TGT_IO       = 3'd3,
    TGT_DRAM     = 3'd4,
    TGT_CAN      = 3'd5,
    TGT_OFFBOARD = 3'd6
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int DEF_ROM_WAIT = 1;
  localparam int DEF_RAM_WAIT = 1;
  localparam int DEF_IO_WAIT  = 2;
  localparam int DEF_CAN_WAIT = 4;
  localparam int DEF_TIMEOUT  = 255;
  localparam int DEF_CNT_W    = 8;

  // sel bit order: [0] ROM, [1] RAM, [2] IO, [3] DRAM, [4] CAN, [5] OffBoard
  function automatic target_e decode_target(input logic [5:0] sel);
    target_e tgt;
    tgt = TGT_NONE;
    if (sel[0])      tgt = TGT_ROM;
    else if (sel[1]) tgt = TGT_RAM;
    else if (sel[2]) tgt = TGT_IO;
    else if (sel[3]) tgt = TGT_DRAM;
    else if (sel[4]) tgt = TGT_CAN;
    else if (sel[5]) tgt = TGT_OFFBOARD;
    return tgt;
  endfunction

  function automatic logic multi_select(input logic [5:0] sel);
    return ($countones(sel) > 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter with zero flag, used for the
// per-region wait-state count. Load has priority over decrement, and the
// count holds at zero rather than wrapping.
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (count -> 0)
//   i_load      load i_load_val this edge
//   i_load_val  value to load
//   i_dec       decrement this edge if nonzero
//   o_zero      count is zero
module wait_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus_cycle_responder.sv
// bus_cycle_responder: target-side responder for the 68000 bus cycle.
// Latches the selected region when AS_L is first sampled low, counts that
// region's wait states (or waits for DRAM ready / external DTACK), then
// drives DTACK_L. BERR_L is driven if nothing answers within TIMEOUT cycles.
//   Clock, Reset_L         clock / async active-low reset
//   AS_L, UDS_L, LDS_L     CPU address and data strobes
//   *Select_H, OffBoard... decoder select lines
//   DramReady_H            DRAM data ready (level)
//   ExtDtack_L             off-board acknowledge
//   DTACK_L, BERR_L        registered handshakes back to the CPU
//   Target                 latched target code
//   MultiSelect_H          one-cycle pulse: overlapping selects at cycle start
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no cycle; waiting for AS_L sampled low
// ST_WAIT  | cycle in progress; counting waits / timeout, awaiting ready
// ST_ACK   | DTACK_L asserted until AS_L sampled high
// ST_ERROR | BERR_L asserted until AS_L sampled high
module bus_cycle_responder
  import bus_pkg::*;
#(
  parameter int ROM_WAIT = DEF_ROM_WAIT,
  parameter int RAM_WAIT = DEF_RAM_WAIT,
  parameter int IO_WAIT  = DEF_IO_WAIT,
  parameter int CAN_WAIT = DEF_CAN_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic       Clock,
  input  logic       Reset_L,
  input  logic       AS_L,
  input  logic       UDS_L,
  input  logic       LDS_L,
  input  logic       OnChipRomSelect_H,
  input  logic       OnChipRamSelect_H,
  input  logic       IOSelect_H,
  input  logic       DramSelect_H,
  input  logic       CanBusSelect_H,
  input  logic       OffBoardMemory_H,
  input  logic       DramReady_H,
  input  logic       ExtDtack_L,
  output logic       DTACK_L,
  output logic       BERR_L,
  output logic [2:0] Target,
  output logic       MultiSelect_H
);

  state_e            r_state;
  target_e           r_target;
  logic              r_dtack_l;
  logic              r_berr_l;
  logic              r_multi;
  logic [CNT_W-1:0]  r_tcnt;

  logic [5:0]        w_sel;
  target_e           w_sel_target;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_load;
  logic              w_dec;
  logic              w_wait_zero;
  logic              w_ready;
  logic              w_strobe;
  logic              w_timeout;
  logic              w_go_ack;

  assign w_sel = {OffBoardMemory_H, CanBusSelect_H, DramSelect_H,
                  IOSelect_H, OnChipRamSelect_H, OnChipRomSelect_H};
  assign w_sel_target = decode_target(w_sel);

  always_comb begin
    w_load_val = '0;
    case (w_sel_target)
      TGT_ROM: w_load_val = CNT_W'(ROM_WAIT);
      TGT_RAM: w_load_val = CNT_W'(RAM_WAIT);
      TGT_IO:  w_load_val = CNT_W'(IO_WAIT);
      TGT_CAN: w_load_val = CNT_W'(CAN_WAIT);
      default: w_load_val = '0;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    case (r_target)
      TGT_ROM, TGT_RAM, TGT_IO, TGT_CAN: w_ready = w_wait_zero;
      TGT_DRAM:                          w_ready = DramReady_H;
      TGT_OFFBOARD:                      w_ready = ~ExtDtack_L;
      default:                           w_ready = 1'b0;
    endcase
  end

  assign w_strobe  = ~UDS_L | ~LDS_L;
  assign w_timeout = (r_tcnt == CNT_W'(TIMEOUT - 1));
  assign w_go_ack  = w_ready & w_strobe;

  // The wait count only advances on edges that fall through to the
  // "keep waiting" branch, so it stays in step with the timeout counter.
  assign w_load = (r_state == ST_IDLE) & ~AS_L;
  assign w_dec  = (r_state == ST_WAIT) & ~AS_L & ~w_timeout & ~w_go_ack;

  wait_counter #(.W(CNT_W)) u_wait_counter (
    .i_clk      (Clock),
    .i_rst_n    (Reset_L),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_wait_zero)
  );

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state   <= ST_IDLE;
      r_target  <= TGT_NONE;
      r_dtack_l <= 1'b1;
      r_berr_l  <= 1'b1;
      r_multi   <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_multi <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!AS_L) begin
            r_target <= w_sel_target;
            r_multi  <= multi_select(w_sel);
            r_tcnt   <= '0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (AS_L) begin
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_berr_l <= 1'b0;
            r_state  <= ST_ERROR;
          end else if (w_go_ack) begin
            r_dtack_l <= 1'b0;
            r_state   <= ST_ACK;
          end else if (r_tcnt != {CNT_W{1'b1}}) begin
            r_tcnt <= r_tcnt + CNT_W'(1);
          end
        end
        ST_ACK: begin
          if (AS_L) begin
            r_dtack_l <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (AS_L) begin
            r_berr_l <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DTACK_L       = r_dtack_l;
  assign BERR_L        = r_berr_l;
  assign Target        = r_target;
  assign MultiSelect_H = r_multi;

endmodule

// File: tb/tb_bus_cycle_responder.sv
module tb_bus_cycle_responder;

  logic       Clock = 1'b0;
  logic       Reset_L;
  logic       AS_L, UDS_L, LDS_L;
  logic       OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
  logic       DramSelect_H, CanBusSelect_H, OffBoardMemory_H;
  logic       DramReady_H, ExtDtack_L;
  logic       DTACK_L, BERR_L, MultiSelect_H;
  logic [2:0] Target;

  int n_checks = 0;
  int n_fail   = 0;
  int n_to     = 0;
  bit cmp_en   = 1'b0;

  localparam int TO = 255;

  bus_cycle_responder dut (
    .Clock             (Clock),
    .Reset_L           (Reset_L),
    .AS_L              (AS_L),
    .UDS_L             (UDS_L),
    .LDS_L             (LDS_L),
    .OnChipRomSelect_H (OnChipRomSelect_H),
    .OnChipRamSelect_H (OnChipRamSelect_H),
    .IOSelect_H        (IOSelect_H),
    .DramSelect_H      (DramSelect_H),
    .CanBusSelect_H    (CanBusSelect_H),
    .OffBoardMemory_H  (OffBoardMemory_H),
    .DramReady_H       (DramReady_H),
    .ExtDtack_L        (ExtDtack_L),
    .DTACK_L           (DTACK_L),
    .BERR_L            (BERR_L),
    .Target            (Target),
    .MultiSelect_H     (MultiSelect_H)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // A bus cycle is "open" from the AS_L-low edge in idle. While open and
  // unanswered, 'elapsed' counts the edges spent waiting; a counted region
  // is ready once elapsed reaches its wait count.
  logic e_dtack, e_berr, e_multi;
  int   e_tgt, elapsed;
  bit   open_cyc;

  function automatic int wait_of(input int t);
    case (t)
      1: return 1;
      2: return 1;
      3: return 2;
      5: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int prio(input logic rom, ram, io, dram, can, off);
    if (rom)  return 1;
    if (ram)  return 2;
    if (io)   return 3;
    if (dram) return 4;
    if (can)  return 5;
    if (off)  return 6;
    return 0;
  endfunction

  function automatic bit target_ready(input int t, input int el);
    if (t == 4) return DramReady_H;
    if (t == 6) return !ExtDtack_L;
    if (t == 0) return 1'b0;
    return el >= wait_of(t);
  endfunction

  always @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      e_dtack = 1'b1; e_berr = 1'b1; e_multi = 1'b0;
      e_tgt = 0; elapsed = 0; open_cyc = 1'b0;
    end else begin
      e_multi = 1'b0;
      if (!open_cyc) begin
        if (!AS_L) begin
          open_cyc = 1'b1;
          elapsed  = 0;
          e_tgt    = prio(OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H,
                          DramSelect_H, CanBusSelect_H, OffBoardMemory_H);
          e_multi  = (int'(OnChipRomSelect_H) + int'(OnChipRamSelect_H) +
                      int'(IOSelect_H) + int'(DramSelect_H) +
                      int'(CanBusSelect_H) + int'(OffBoardMemory_H)) >= 2;
        end
      end else if (!e_dtack || !e_berr) begin
        if (AS_L) begin
          e_dtack = 1'b1; e_berr = 1'b1; open_cyc = 1'b0;
        end
      end else if (AS_L) begin
        open_cyc = 1'b0;
      end else if (elapsed == TO - 1) begin
        e_berr = 1'b0;
      end else if (target_ready(e_tgt, elapsed) && (!UDS_L || !LDS_L)) begin
        e_dtack = 1'b0;
      end else begin
        elapsed++;
      end
    end
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("model_dtack",  int'(DTACK_L),       int'(e_dtack));
      chk("model_berr",   int'(BERR_L),        int'(e_berr));
      chk("model_target", int'(Target),        e_tgt);
      chk("model_multi",  int'(MultiSelect_H), int'(e_multi));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic set_sel(input logic [5:0] s);
    OnChipRomSelect_H = s[0];
    OnChipRamSelect_H = s[1];
    IOSelect_H        = s[2];
    DramSelect_H      = s[3];
    CanBusSelect_H    = s[4];
    OffBoardMemory_H  = s[5];
  endtask

  task automatic release_bus();
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    set_sel(6'b0);
    DramReady_H = 1'b0; ExtDtack_L = 1'b1;
  endtask

  task automatic rand_cycle();
    int r, sd, dd, ed, ab, k;
    logic [5:0] sel;
    bit done;
    r = $urandom_range(0, 19);
    if (r < 14)      sel = 6'b1 << (r % 6);
    else if (r < 18) sel = (6'b1 << $urandom_range(0, 5)) | (6'b1 << $urandom_range(0, 5));
    else if (n_to < 3) begin sel = 6'b0; n_to++; end
    else             sel = 6'b000100;
    set_sel(sel);
    AS_L = 1'b0;
    sd = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
    dd = $urandom_range(0, 8);
    ed = $urandom_range(0, 8);
    ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : -1;
    k  = $urandom_range(0, 2);
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      UDS_L       = !((t >= sd) && (k != 2));
      LDS_L       = !((t >= sd) && (k != 1));
      DramReady_H = (t >= dd);
      ExtDtack_L  = !(t >= ed);
      tick();
      if (!DTACK_L || !BERR_L) done = 1'b1;
      else if (t + 1 == ab)    done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL rand_bound: no DTACK_L/BERR_L within 300 cycles, got DTACK_L=%0b BERR_L=%0b required one low",
               DTACK_L, BERR_L);
    end
    repeat ($urandom_range(0, 2)) begin
      UDS_L = 1'($urandom);
      LDS_L = 1'($urandom);
      tick();
    end
    release_bus();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    Reset_L = 1'b0;
    release_bus();
    repeat (3) @(negedge Clock);
    chk("rst_dtack",  int'(DTACK_L), 1);
    chk("rst_berr",   int'(BERR_L), 1);
    chk("rst_target", int'(Target), 0);
    chk("rst_multi",  int'(MultiSelect_H), 0);
    #2 Reset_L = 1'b1;
    cmp_en = 1'b1;
    tick();

    // ROM read: one wait state
    set_sel(6'b000001); AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    chk("rom_target_e0", int'(Target), 1);
    chk("rom_dtack_e0",  int'(DTACK_L), 1);
    tick();
    chk("rom_dtack_e1",  int'(DTACK_L), 1);
    tick();
    chk("rom_dtack_e2",  int'(DTACK_L), 0);
    release_bus();
    tick();
    chk("rom_release",   int'(DTACK_L), 1);
    tick();

    // DRAM read: ready arrives before edge 7
    set_sel(6'b001000); AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    repeat (6) tick();
    chk("dram_dtack_e6", int'(DTACK_L), 1);
    DramReady_H = 1'b1;
    tick();
    chk("dram_dtack_e7", int'(DTACK_L), 0);
    chk("dram_berr_e7",  int'(BERR_L), 1);
    chk("dram_target",   int'(Target), 4);
    release_bus();
    repeat (2) tick();

    // Unmapped: bus error after edge 255
    AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    repeat (254) tick();
    chk("unmap_berr_e254", int'(BERR_L), 1);
    tick();
    chk("unmap_berr_e255", int'(BERR_L), 0);
    chk("unmap_dtack",     int'(DTACK_L), 1);
    chk("unmap_target",    int'(Target), 0);
    release_bus();
    tick();
    chk("unmap_release",   int'(BERR_L), 1);
    tick();

    // IO write with late strobe
    set_sel(6'b000100); AS_L = 1'b0;
    tick();
    repeat (5) tick();
    chk("io_dtack_e5", int'(DTACK_L), 1);
    UDS_L = 1'b0;
    tick();
    chk("io_dtack_e6", int'(DTACK_L), 0);
    release_bus();
    repeat (2) tick();

    // CAN cycle aborted before its waits complete
    set_sel(6'b010000); AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    tick();
    release_bus();
    tick();
    chk("can_abort_dtack",  int'(DTACK_L), 1);
    chk("can_abort_target", int'(Target), 5);
    repeat (5) tick();
    chk("can_abort_late",   int'(DTACK_L), 1);

    // Reset asserted while acknowledging
    set_sel(6'b000001); AS_L = 1'b0; LDS_L = 1'b0;
    repeat (3) tick();
    chk("rstack_dtack_before", int'(DTACK_L), 0);
    #2 Reset_L = 1'b0;
    #1;
    chk("rstack_dtack_async", int'(DTACK_L), 1);
    chk("rstack_target",      int'(Target), 0);
    release_bus();
    @(negedge Clock);
    #2 Reset_L = 1'b1;
    tick();
    chk("rstack_after", int'(DTACK_L), 1);

    // Overlapping ROM and IO selects
    set_sel(6'b000101); AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    chk("ovl_multi_e0",  int'(MultiSelect_H), 1);
    chk("ovl_target",    int'(Target), 1);
    tick();
    chk("ovl_multi_e1",  int'(MultiSelect_H), 0);
    chk("ovl_dtack_e1",  int'(DTACK_L), 1);
    tick();
    chk("ovl_dtack_e2",  int'(DTACK_L), 0);
    release_bus();
    repeat (2) tick();

    repeat (150) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_cycle_responder.md
Name: bus_cycle_responder

Overview:
- Target-side responder for the 68000 bus cycle: the counterpart to the address decoder.
- Consumes the decoder's per-region select lines and the CPU strobes. Counts per-region wait states, or waits for device-ready handshakes, then drives DTACK_L back to the CPU.
- Drives BERR_L when no target answers within a timeout.
- Sits between the decoder outputs and the CPU's DTACK_L/BERR_L inputs; the CPU runs on the same Clock.

Parameters:
- ROM_WAIT, 1, wait-state count for on-chip ROM
- RAM_WAIT, 1, wait-state count for on-chip RAM
- IO_WAIT, 2, wait-state count for the IO region
- CAN_WAIT, 4, wait-state count for the CAN bus controller
- TIMEOUT, 255, cycles in WAIT before bus error (must be > every *_WAIT)
- CNT_W, 8, width of the wait and timeout counters (2**CNT_W > TIMEOUT)

Ports:
- Clock  in  1  system clock, rising-edge
- Reset_L  in  1  asynchronous, active-low reset
- AS_L  in  1  CPU address strobe
- UDS_L  in  1  upper data strobe
- LDS_L  in  1  lower data strobe
- OnChipRomSelect_H  in  1  decoder select
- OnChipRamSelect_H  in  1  decoder select
- IOSelect_H  in  1  decoder select
- DramSelect_H  in  1  decoder select
- CanBusSelect_H  in  1  decoder select
- OffBoardMemory_H  in  1  decoder select
- DramReady_H  in  1  DRAM controller data-ready, level
- ExtDtack_L  in  1  off-board device acknowledge
- DTACK_L  out  1  data transfer acknowledge to CPU, registered
- BERR_L  out  1  bus error to CPU, registered
- Target  out  3  latched target code: 0 none, 1 ROM, 2 RAM, 3 IO, 4 DRAM, 5 CAN, 6 OffBoard
- MultiSelect_H  out  1  one-cycle pulse: more than one select was high at cycle start

Behaviour:
- Reset (async, Reset_L low): DTACK_L=1, BERR_L=1, Target=0, MultiSelect_H=0, state IDLE, counters 0. Takes effect immediately, including mid-cycle; outputs stay inactive until Reset_L is released and a new AS_L low is sampled in IDLE.
- States: IDLE, WAIT, ACK, ERROR.
- IDLE:
  - On an edge sampling AS_L=0, latch Target by priority ROM>RAM>IO>DRAM>CAN>OffBoard, load the wait counter from that region's *_WAIT (0 for DRAM/OffBoard), clear the timeout counter, go to WAIT.
  - MultiSelect_H=1 for that one cycle if two or more selects were high.
  - No select high: Target=0, go to WAIT; only the timeout can end the cycle.
- WAIT, evaluated each edge in this order:
  - (a) AS_L=1: abort, go to IDLE, no acknowledge, Target held.
  - (b) Timeout counter == TIMEOUT-1: go to ERROR.
  - (c) Ready condition true and (UDS_L=0 or LDS_L=0): go to ACK.
  - (d) Otherwise decrement the wait counter if nonzero and increment the timeout counter.
- Ready condition per target:
  - ROM/RAM/IO/CAN: wait counter == 0.
  - DRAM: DramReady_H=1.
  - OffBoard: ExtDtack_L=0.
  - None: never.
- Latency: AS_L sampled low at edge k with N wait states and strobes already low gives DTACK_L low after edge k+N+1 (N=0 gives k+1).
- Write cycles: late data strobes simply extend WAIT; they do not affect the wait count.
- ACK: DTACK_L=0 held until an edge samples AS_L=1, then DTACK_L=1 and go to IDLE. Strobes toggling in ACK are ignored.
- ERROR: BERR_L=0 held until an edge samples AS_L=1, then BERR_L=1 and go to IDLE. DTACK_L is never low in the same cycle as BERR_L.
- Back-to-back cycles: AS_L must be sampled high at least once between cycles; a new cycle cannot start in the same edge that exits ACK or ERROR.
- Timeout counter saturates; it never wraps.

Decomposition:
- Shared package, bus_pkg:
  - target code enum (TGT_NONE..TGT_OFFBOARD)
  - state enum
  - default wait-state constants
- Sub-module wait_counter: loadable down-counter with zero flag, instantiated for the wait count. The timeout uses a plain up-counter inline.

Test Plan:
- ROM read: ROM select=1, AS_L and LDS_L low at edge 0 → DTACK_L low after edge 2, Target=1; AS_L high → DTACK_L high the next edge.
- DRAM read: DramSelect_H=1, DramReady_H rises at cycle 7 → DTACK_L low the edge after, BERR_L stays 1.
- Unmapped address: no select, AS_L low → BERR_L low after edge 255, Target=0, DTACK_L never low; AS_L high releases BERR_L.
- IO write with late strobe: IOSelect_H=1, UDS_L low at cycle 5 → DTACK_L low after edge 6 (not 3).
- Abort and reset: AS_L high during a CAN WAIT at cycle 2 → IDLE with no DTACK_L. Reset_L low during ACK → DTACK_L=1 immediately, asynchronously.
- Overlap: ROM and IO selects both high → Target=1, MultiSelect_H pulses for 1 cycle, timing follows ROM_WAIT.
